addsub_arbiter: RTL



---
 rtl/addsub_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one 4-bit add/subtract datapath between two
// valid/ready requesters, returning a registered result with signed overflow.

module addsub #(
  parameter int WIDTH = 4
) (
  output logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mode
);
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] r_s;

  assign a_s    = operand_a;
  assign b_s    = operand_b;
  assign r_s    = mode ? (a_s - b_s) : (a_s + b_s);
  assign result = r_s;
endmodule

module addsub_arbiter #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_mode,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_mode,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_ovf,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                  state;
  logic                    last_grant;
  logic signed [WIDTH-1:0] a_p0;
  logic signed [WIDTH-1:0] b_p0;
  logic                    mode_p0;
  logic                    id_p0;
  logic [WIDTH-1:0]        sum_p1;
  logic                    grant0;
  logic                    grant1;
  logic                    consume;

  function automatic logic ovf_calc(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic        [WIDTH-1:0] r,
    input logic                    sub
  );
    logic same_in;
    same_in = (a[WIDTH-1] == b[WIDTH-1]);
    if (sub) return !same_in && (r[WIDTH-1] != a[WIDTH-1]);
    else     return  same_in && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  // Under contention the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant);
  assign grant1 = req1_valid && (!req0_valid || !last_grant);

  // Nothing is accepted while reset is held, even though the state reads IDLE.
  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;

  assign busy    = (state != IDLE);
  assign consume = id_p0 ? rsp1_ready : rsp0_ready;

  addsub #(.WIDTH(WIDTH)) u_addsub (
    .result    (sum_p1),
    .operand_a (a_p0),
    .operand_b (b_p0),
    .mode      (mode_p0)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      a_p0       <= '0;
      b_p0       <= '0;
      mode_p0    <= 1'b0;
      id_p0      <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp_result <= '0;
      rsp_ovf    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (state)
        // p0: capture the granted operands; requesters may change them afterwards
        IDLE: begin
          if (req0_valid && req0_ready) begin
            a_p0    <= req0_a;
            b_p0    <= req0_b;
            mode_p0 <= req0_mode;
            id_p0   <= 1'b0;
            state   <= EXEC;
          end else if (req1_valid && req1_ready) begin
            a_p0    <= req1_a;
            b_p0    <= req1_b;
            mode_p0 <= req1_mode;
            id_p0   <= 1'b1;
            state   <= EXEC;
          end
        end
        // p1: register the shared datapath output and raise the issuer's valid
        EXEC: begin
          rsp_result <= sum_p1;
          rsp_ovf    <= ovf_calc(a_p0, b_p0, sum_p1, mode_p0);
          rsp0_valid <= !id_p0;
          rsp1_valid <= id_p0;
          state      <= RESP;
        end
        // p2: hold the response until the issuing requester takes it
        RESP: begin
          if (consume) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            op_count   <= op_count + 1'b1;
            last_grant <= id_p0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
